// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the memory arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int WIDTH     = 16
);
    localparam int NB = WIDTH / 8;

    logic [NUM_PORTS-1:0]       req_read;
    logic [NUM_PORTS-1:0]       req_write;
    logic [NUM_PORTS*NB-1:0]    req_wmask;
    logic [NUM_PORTS*WIDTH-1:0] req_address;
    logic [NUM_PORTS*WIDTH-1:0] req_wdata;
    logic [NUM_PORTS-1:0]       req_resp;
    logic [WIDTH-1:0]           req_rdata;

    logic                       mem_read;
    logic                       mem_write;
    logic [NB-1:0]              mem_byte_enable;
    logic [WIDTH-1:0]           mem_address;
    logic [WIDTH-1:0]           mem_wdata;
    logic                       mem_resp;
    logic [WIDTH-1:0]           mem_rdata;

    modport slave (
        input  req_read, req_write, req_wmask, req_address, req_wdata, mem_resp, mem_rdata,
        output req_resp, req_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );

    modport master (
        output req_read, req_write, req_wmask, req_address, req_wdata, mem_resp, mem_rdata,
        input  req_resp, req_rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// N-to-1 memory port arbiter (round-robin or fixed priority) with a
// response watchdog that aborts a stalled transaction and flags it.
module mem_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int WIDTH         = 16,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic         timeout_err
);
    localparam int NB = WIDTH / 8;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        grant, grant_nxt, ptr, ptr_nxt, winner;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 err_nxt;
    logic [NUM_PORTS-1:0] req_any;
    logic                 busy, wd_fire, done;

    logic [WIDTH-1:0]     p_addr  [NUM_PORTS];
    logic [WIDTH-1:0]     p_wdata [NUM_PORTS];
    logic [NB-1:0]        p_mask  [NUM_PORTS];

    assign req_any = bus.req_read | bus.req_write;
    assign busy    = (state == BUSY);
    assign wd_fire = (TIMEOUT > 0) && busy && !bus.mem_resp && (cnt == CNT_LAST);
    assign done    = busy && (bus.mem_resp || wd_fire);

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign p_addr[i]       = bus.req_address[i*WIDTH +: WIDTH];
        assign p_wdata[i]      = bus.req_wdata[i*WIDTH +: WIDTH];
        assign p_mask[i]       = bus.req_wmask[i*NB +: NB];
        assign bus.req_resp[i] = done && (grant == PW'(i));
    end

    // Lowest requester overall, then (round-robin only) lowest requester at or above ptr.
    always_comb begin
        winner = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--)
            if (req_any[j]) winner = PW'(j);
        if (PRIORITY_MODE == 0)
            for (int j = NUM_PORTS - 1; j >= 0; j--)
                if (req_any[j] && (PW'(j) >= ptr)) winner = PW'(j);
    end

    always_comb begin
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        if (busy) begin
            bus.mem_write       = bus.req_write[grant];
            bus.mem_read        = bus.req_read[grant] & ~bus.req_write[grant];
            bus.mem_byte_enable = p_mask[grant];
            bus.mem_address     = p_addr[grant];
            bus.mem_wdata       = p_wdata[grant];
        end
    end

    // Aborted transactions return zero data.
    assign bus.req_rdata = (busy && bus.mem_resp) ? bus.mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            ptr         <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        err_nxt   = timeout_err;
        case (state)
            IDLE: begin
                if (|req_any) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + 1'b1;
                if (done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = (grant == LAST_PORT) ? '0 : grant + 1'b1;
                    if (wd_fire) err_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
